dispense_sequencer: RTL and testbench
=====================================

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 The module SHALL have parameter SMALL_STEPS, default 200, giving the stepper full steps for amount 2'b00.
REQ-002 The module SHALL have parameter MED_STEPS, default 400, giving the stepper full steps for amount 2'b01.
REQ-003 The module SHALL have parameter LARGE_STEPS, default 800, giving the stepper full steps for amount 2'b10.
REQ-004 The module SHALL have parameter DC_TICKS, default 1000, giving the duration of the DC motor phase in step_tick pulses.
REQ-005 The module SHALL have parameter PWM_PERIOD, default 100, giving the DC PWM period in pwm_tick pulses.
REQ-006 The module SHALL have parameter PWM_DUTY, default 50, giving the DC PWM high time in pwm_tick pulses (PWM_DUTY <= PWM_PERIOD).
REQ-007 clk  in  1  single system clock; every flop SHALL be clocked on the rising edge of clk.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 step_tick  in  1  one-clk enable pulse from the stepper clock divider.
REQ-010 pwm_tick  in  1  one-clk enable pulse from the DC clock divider.
REQ-011 req  in  1  level-sensitive dispense request (candyflag) from the Raspberry Pi.
REQ-012 amount  in  2  dispense size: 00 small, 01 medium, 10 large, 11 invalid.
REQ-013 stepper_step  out  1  stepper STEP pin.
REQ-014 stepper_dir  out  1  stepper DIR pin, held at 0.
REQ-015 dc_dir  out  2  DC direction pins: [0] maps to IO_B9, [1] maps to IO_F7.
REQ-016 dc_pwm  out  1  DC speed PWM.
REQ-017 ack  out  1  handshake to the Pi, meaning the dispense completed.
REQ-018 busy  out  1  high while in STEP or DC.
REQ-019 err  out  1  high while an invalid request is held.

Function
REQ-020 The FSM SHALL have the states IDLE, STEP, DC, DONE and ERR, with every output registered.
REQ-021 Idle outputs SHALL be: stepper_step=0, stepper_dir=0, dc_dir=2'b10, dc_pwm=0, ack=0, busy=0, err=0.
REQ-022 In IDLE with req=1, the FSM SHALL capture amount into amt_q and enter STEP on the next clk, or ERR if amount=11.
REQ-023 In STEP, on each step_tick, the FSM SHALL toggle stepper_step, and SHALL increment the 12-bit step_cnt on each falling toggle (1->0).
REQ-024 The FSM SHALL leave STEP for DC when step_cnt reaches the target for amt_q; the transition SHALL occur on the same clk as the final falling toggle, and step_cnt SHALL then be cleared.
REQ-025 In DC, the FSM SHALL set dc_dir=2'b01.
REQ-026 In DC, the 8-bit pwm_cnt SHALL advance on pwm_tick and wrap from PWM_PERIOD-1 to 0.
REQ-027 dc_pwm SHALL be 1 while pwm_cnt < PWM_DUTY; pwm_cnt SHALL be 0 on entry to DC.
REQ-028 In DC, the 12-bit dc_cnt SHALL increment on step_tick, and the FSM SHALL enter DONE when dc_cnt reaches DC_TICKS.
REQ-029 In DONE, ack SHALL be 1 and the motors SHALL be at idle values; when req=0, the FSM SHALL enter IDLE and ack SHALL be 0 on the next clk.
REQ-030 In ERR, err SHALL be 1 and ack SHALL be 0; when req=0, the FSM SHALL return to IDLE.
REQ-031 If req=0 in STEP or DC (abort), the FSM SHALL return to IDLE on the next clk with idle outputs, clear all counters, and never assert ack.
REQ-032 If req falls in the same clk as step_tick or pwm_tick, abort SHALL win and no counter SHALL update.
REQ-033 Changes on amount after capture SHALL be ignored until the next IDLE.
REQ-034 A new dispense SHALL require req to be low for at least one clk in IDLE; req held high in IDLE after DONE or ERR SHALL NOT retrigger.
REQ-035 Ticks arriving while the FSM is in IDLE, DONE or ERR SHALL have no effect.

Reset
REQ-036 With rst=1 at a clk edge, the FSM SHALL be in IDLE on the next cycle with idle outputs and step_cnt, dc_cnt, pwm_cnt and amt_q all zero, including when reset occurs mid-STEP or mid-DC.
REQ-037 rst SHALL take priority over all other inputs.

Verification
(bench overrides: SMALL=3, MED=5, LARGE=7, DC_TICKS=4, PWM_PERIOD=4, PWM_DUTY=2)
REQ-038 req=1 with amount=00, step_tick every 4 clk -> exactly 3 stepper_step pulses, then dc_dir=01 with dc_pwm pattern 1,1,0,0 per pwm_tick, then ack=1 after 4 step_ticks; req=0 -> ack=0 one clk later.
REQ-039 req=1 with amount=10 -> 7 step pulses; amount driven to 00 mid-STEP -> pulse count still 7.
REQ-040 req=1 with amount=11 -> err=1, stepper_step=0, dc_pwm=0, ack=0; req=0 -> err=0.
REQ-041 req falls after the 2nd pulse of amount=01 -> next clk idle outputs, no ack; a later request runs a full 5 pulses.
REQ-042 rst=1 mid-DC -> next clk dc_dir=10, dc_pwm=0, busy=0; req still high -> no restart until req toggles low then high.
REQ-043 req falling in the same clk as step_tick during STEP -> stepper_step=0 and step_cnt=0 next clk.

Source files
------------

// File: rtl/dispense_sequencer.sv
// dispense_sequencer: stepper dose then timed DC PWM phase, handshaked with the host via req/ack.
module dispense_sequencer #(
   parameter int SMALL_STEPS = 200,
   parameter int MED_STEPS   = 400,
   parameter int LARGE_STEPS = 800,
   parameter int DC_TICKS    = 1000,
   parameter int PWM_PERIOD  = 100,
   parameter int PWM_DUTY    = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_tick,
   input  logic       pwm_tick,
   input  logic       req,
   input  logic [1:0] amount,
   output logic       stepper_step,
   output logic       stepper_dir,
   output logic [1:0] dc_dir,
   output logic       dc_pwm,
   output logic       ack,
   output logic       busy,
   output logic       err
);
   typedef enum logic [2:0] {IDLE, STEP, DC, DONE, ERR} state_e;
   localparam logic [11:0] S_T    = 12'(SMALL_STEPS);
   localparam logic [11:0] M_T    = 12'(MED_STEPS);
   localparam logic [11:0] L_T    = 12'(LARGE_STEPS);
   localparam logic [11:0] DC_T   = 12'(DC_TICKS);
   localparam logic [7:0]  P_LAST = 8'(PWM_PERIOD - 1);
   localparam logic [7:0]  P_DUTY = 8'(PWM_DUTY);
   state_e      state_q, state_d;
   logic [1:0]  amt_q, amt_d;
   logic        step_q, step_d;
   logic        arm_q, arm_d;
   logic [11:0] step_cnt_q, step_cnt_d;
   logic [11:0] dc_cnt_q, dc_cnt_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;
   logic [11:0] target;
   assign target = amt_q == 2'b00 ? S_T : amt_q == 2'b01 ? M_T : L_T;
   always_comb begin
      state_d    = state_q;
      amt_d      = amt_q;
      step_d     = step_q;
      arm_d      = arm_q;
      step_cnt_d = step_cnt_q;
      dc_cnt_d   = dc_cnt_q;
      pwm_cnt_d  = pwm_cnt_q;
      case (state_q)
         IDLE: begin
            arm_d = arm_q | ~req;
            if (req && arm_q) begin
               amt_d   = amount;
               arm_d   = 1'b0;
               state_d = amount == 2'b11 ? ERR : STEP;
            end
         end
         STEP: begin
            if (!req) state_d = IDLE;
            else if (step_tick) begin
               step_d = ~step_q;
               if (step_q) begin
                  step_cnt_d = step_cnt_q + 12'd1;
                  if (step_cnt_d == target) state_d = DC;
               end
            end
         end
         DC: begin
            if (!req) state_d = IDLE;
            else begin
               if (pwm_tick) pwm_cnt_d = pwm_cnt_q == P_LAST ? 8'd0 : pwm_cnt_q + 8'd1;
               if (step_tick) begin
                  dc_cnt_d = dc_cnt_q + 12'd1;
                  if (dc_cnt_d == DC_T) state_d = DONE;
               end
            end
         end
         DONE, ERR: state_d = req ? state_q : IDLE;
         default: state_d = IDLE;
      endcase
      // Each phase's counters live only while that phase is (still) active.
      if (state_d != STEP) begin
         step_d     = 1'b0;
         step_cnt_d = 12'd0;
      end
      if (state_d != DC) begin
         dc_cnt_d  = 12'd0;
         pwm_cnt_d = 8'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         amt_q        <= 2'b00;
         step_q       <= 1'b0;
         arm_q        <= 1'b0;
         step_cnt_q   <= 12'd0;
         dc_cnt_q     <= 12'd0;
         pwm_cnt_q    <= 8'd0;
         stepper_step <= 1'b0;
         stepper_dir  <= 1'b0;
         dc_dir       <= 2'b10;
         dc_pwm       <= 1'b0;
         ack          <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_q      <= state_d;
         amt_q        <= amt_d;
         step_q       <= step_d;
         arm_q        <= arm_d;
         step_cnt_q   <= step_cnt_d;
         dc_cnt_q     <= dc_cnt_d;
         pwm_cnt_q    <= pwm_cnt_d;
         stepper_step <= step_d;
         stepper_dir  <= 1'b0;
         dc_dir       <= state_d == DC ? 2'b01 : 2'b10;
         dc_pwm       <= state_d == DC && pwm_cnt_d < P_DUTY;
         ack          <= state_d == DONE;
         busy         <= state_d == STEP || state_d == DC;
         err          <= state_d == ERR;
      end
   end
endmodule

// File: tb/tb_dispense_sequencer.sv
// tb_dispense_sequencer: directed and random stimulus against a tick-counting reference model.
module tb_dispense_sequencer;
   localparam int SM = 3, MD = 5, LG = 7, DT = 4, PP = 4, PD = 2;
   localparam int M_IDLE = 0, M_STEP = 1, M_DC = 2, M_DONE = 3, M_ERR = 4;
   logic clk = 1'b0;
   logic rst = 1'b1, step_tick = 1'b0, pwm_tick = 1'b0, req = 1'b0;
   logic [1:0] amount = 2'b00;
   logic stepper_step, stepper_dir, dc_pwm, ack, busy, err;
   logic [1:0] dc_dir;
   int n_vec = 0, n_err = 0;
   int mode = M_IDLE, ticks = 0, dct = 0, pwmt = 0, amt = 0;
   bit armed = 1'b0;
   always #5 clk = ~clk;
   dispense_sequencer #(
      .SMALL_STEPS(SM), .MED_STEPS(MD), .LARGE_STEPS(LG),
      .DC_TICKS(DT), .PWM_PERIOD(PP), .PWM_DUTY(PD)
   ) dut (
      .clk(clk), .rst(rst), .step_tick(step_tick), .pwm_tick(pwm_tick),
      .req(req), .amount(amount), .stepper_step(stepper_step),
      .stepper_dir(stepper_dir), .dc_dir(dc_dir), .dc_pwm(dc_pwm),
      .ack(ack), .busy(busy), .err(err)
   );
   function automatic int steps_for(int a);
      return a == 0 ? SM : a == 1 ? MD : LG;
   endfunction
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask
   // A dispense is 2*N step ticks (rise+fall per pulse), then DT step ticks of DC.
   task automatic cyc(input bit r, input bit q, input int a, input bit st, input bit pt);
      @(negedge clk);
      rst = r; req = q; amount = 2'(a); step_tick = st; pwm_tick = pt;
      if (r) begin
         mode = M_IDLE; ticks = 0; dct = 0; pwmt = 0; amt = 0; armed = 1'b0;
      end else case (mode)
         M_IDLE:
            if (q && armed) begin
               amt = a; armed = 1'b0; ticks = 0;
               mode = a == 3 ? M_ERR : M_STEP;
            end else if (!q) armed = 1'b1;
         M_STEP:
            if (!q) mode = M_IDLE;
            else if (st) begin
               ticks++;
               if (ticks == 2 * steps_for(amt)) begin
                  mode = M_DC; dct = 0; pwmt = 0;
               end
            end
         M_DC:
            if (!q) mode = M_IDLE;
            else begin
               if (pt) pwmt++;
               if (st) begin
                  dct++;
                  if (dct == DT) mode = M_DONE;
               end
            end
         default: if (!q) mode = M_IDLE;
      endcase
      @(posedge clk);
      #1;
      chk("stepper_step", 8'(stepper_step), 8'(mode == M_STEP && ticks % 2 == 1));
      chk("stepper_dir", 8'(stepper_dir), 8'd0);
      chk("dc_dir", 8'(dc_dir), mode == M_DC ? 8'd1 : 8'd2);
      chk("dc_pwm", 8'(dc_pwm), 8'(mode == M_DC && pwmt % PP < PD));
      chk("ack", 8'(ack), 8'(mode == M_DONE));
      chk("busy", 8'(busy), 8'(mode == M_STEP || mode == M_DC));
      chk("err", 8'(err), 8'(mode == M_ERR));
   endtask
   initial begin
      bit rq;
      int ra;
      repeat (2) cyc(1, 0, 0, 0, 0);
      repeat (2) cyc(0, 0, 0, 1, 1);
      for (int i = 0; i < 80; i++) cyc(0, 1, 0, i % 4 == 3, i % 2 == 1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 70; i++) cyc(0, 1, i < 20 ? 2 : 0, i % 3 == 2, 1);
      repeat (2) cyc(0, 0, 0, 0, 0);
      repeat (4) cyc(0, 1, 3, 1, 1);
      repeat (2) cyc(0, 0, 3, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0);
      repeat (2) cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 12; i++) cyc(0, 1, 1, 1, 1);
      cyc(1, 1, 1, 1, 1);
      repeat (6) cyc(0, 1, 1, 1, 1);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, i % 2, 0);
      cyc(0, 0, 0, 1, 1);
      rq = 1'b0; ra = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 59) == 0) rq = ~rq;
         if ($urandom_range(0, 7) == 0) ra = int'($urandom_range(0, 3));
         cyc($urandom_range(0, 299) == 0, rq, ra,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
